// File: rtl/mouse_frame_ctl_pkg.sv
// mouse_frame_ctl_pkg: shared widths and fire FSM state type for the player input path
package mouse_frame_ctl_pkg;
    localparam int POS_W      = 11;
    localparam int COOL_CNT_W = 4;
    typedef enum logic [1:0] {IDLE, REQ, COOL} fire_state_t;
endpackage

// File: rtl/mouse_frame_ctl_pos_clamp.sv
// pos_clamp: combinational unsigned clamp of val into [LO, HI]; val in, clamped out
module pos_clamp
    import mouse_frame_ctl_pkg::*;
#(
    parameter int LO = 0,
    parameter int HI = (1 << POS_W) - 1
) (
    input  logic [POS_W-1:0] val,
    output logic [POS_W-1:0] clamped
);
    always_comb clamped = int'(val) < LO ? POS_W'(LO) : int'(val) > HI ? POS_W'(HI) : val;
endmodule

// File: rtl/mouse_frame_ctl.sv
// mouse_frame_ctl: per-frame position capture with clamping and a fire req/ack handshake with cooldown
//   pclk, rst_n                  clock, async active-low reset
//   vblnk_in                     vertical blanking; rising edge triggers a capture
//   xpos_in, ypos_in, left_in    registered mouse state
//   shot_ack                     bullet engine acceptance pulse
//   xpos_out, ypos_out           clamped positions, stable for a frame
//   frame_tick                   one-cycle pulse when new positions appear
//   fire_req                     shot request, held until acknowledged
module mouse_frame_ctl
    import mouse_frame_ctl_pkg::*;
#(
    parameter int X_MIN           = 0,
    parameter int X_MAX           = 767,
    parameter int Y_MIN           = 400,
    parameter int Y_MAX           = 567,
    parameter int COOLDOWN_FRAMES = 8
) (
    input  logic             pclk,
    input  logic             rst_n,
    input  logic             vblnk_in,
    input  logic [POS_W-1:0] xpos_in,
    input  logic [POS_W-1:0] ypos_in,
    input  logic             left_in,
    input  logic             shot_ack,
    output logic [POS_W-1:0] xpos_out,
    output logic [POS_W-1:0] ypos_out,
    output logic             frame_tick,
    output logic             fire_req
);
    localparam logic [COOL_CNT_W-1:0] CNT_LOAD = COOL_CNT_W'(COOLDOWN_FRAMES - 1);
    logic                  vblnk_d;
    logic                  capture;
    logic [POS_W-1:0]      x_cl, y_cl;
    fire_state_t           state, state_nxt;
    logic [COOL_CNT_W-1:0] cnt, cnt_nxt;
    assign capture  = vblnk_in & ~vblnk_d;
    assign fire_req = state == REQ;
    pos_clamp #(.LO(X_MIN), .HI(X_MAX)) u_x (.val(xpos_in), .clamped(x_cl));
    pos_clamp #(.LO(Y_MIN), .HI(Y_MAX)) u_y (.val(ypos_in), .clamped(y_cl));
    // vblnk_d resets high so a blanking level already present at release is not an edge
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            vblnk_d    <= 1'b1;
            xpos_out   <= POS_W'(X_MIN);
            ypos_out   <= POS_W'(Y_MIN);
            frame_tick <= 1'b0;
            state      <= IDLE;
            cnt        <= '0;
        end else begin
            vblnk_d    <= vblnk_in;
            frame_tick <= capture;
            if (capture) begin
                xpos_out <= x_cl;
                ypos_out <= y_cl;
            end
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end
    // an ack in REQ wins over a coincident capture, so the cooldown starts full
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: state_nxt = capture && left_in ? REQ : IDLE;
            REQ: begin
                state_nxt = shot_ack ? COOL : REQ;
                cnt_nxt   = shot_ack ? CNT_LOAD : cnt;
            end
            COOL: begin
                state_nxt = capture && cnt == '0 ? IDLE : COOL;
                cnt_nxt   = capture && cnt != '0 ? cnt - 1'b1 : cnt;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mouse_frame_ctl.sv
// tb_mouse_frame_ctl: directed vector table plus handshake/cooldown/reset sequences
module tb_mouse_frame_ctl;
    logic        pclk = 1'b0;
    logic        rst_n;
    logic        vblnk_in;
    logic [10:0] xpos_in, ypos_in;
    logic        left_in, shot_ack;
    logic [10:0] xpos_out, ypos_out;
    logic        frame_tick, fire_req;
    int          n_pass = 0;
    int          n_total = 0;
    typedef struct {
        logic        v;
        logic [10:0] x, y;
        logic        l, a;
        logic [10:0] ex, ey;
        logic        et, er;
    } vec_t;
    vec_t tbl[11];
    mouse_frame_ctl dut (
        .pclk(pclk), .rst_n(rst_n), .vblnk_in(vblnk_in), .xpos_in(xpos_in), .ypos_in(ypos_in),
        .left_in(left_in), .shot_ack(shot_ack), .xpos_out(xpos_out), .ypos_out(ypos_out),
        .frame_tick(frame_tick), .fire_req(fire_req)
    );
    always #5 pclk = ~pclk;
    task automatic chk(input string name, input logic [10:0] got, input logic [10:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got %0d, want %0d", name, got, exp);
        else n_pass++;
    endtask
    task automatic step(input logic v, input logic l, input logic a);
        vblnk_in = v;
        left_in  = l;
        shot_ack = a;
        @(posedge pclk);
        #1;
    endtask
    task automatic chk_reset(input string tag);
        chk({tag, " x"}, xpos_out, 11'd0);
        chk({tag, " y"}, ypos_out, 11'd400);
        chk({tag, " tick"}, {10'd0, frame_tick}, 11'd0);
        chk({tag, " req"}, {10'd0, fire_req}, 11'd0);
    endtask
    // from COOL with cnt=7: the request returns on the 9th capture
    task automatic cool_wait(input string tag);
        for (int k = 1; k <= 9; k++) begin
            step(1'b1, 1'b1, k == 4);
            chk($sformatf("%s cap%0d tick", tag, k), {10'd0, frame_tick}, 11'd1);
            chk($sformatf("%s cap%0d req", tag, k), {10'd0, fire_req}, {10'd0, k == 9});
            step(1'b0, 1'b1, k == 2);
            chk($sformatf("%s gap%0d tick", tag, k), {10'd0, frame_tick}, 11'd0);
            chk($sformatf("%s gap%0d req", tag, k), {10'd0, fire_req}, {10'd0, k == 9});
        end
    endtask
    initial begin
        //          v     x        y        l     a     ex       ey       tick  req
        tbl[0]  = '{1'b1, 11'd900, 11'd100, 1'b0, 1'b0, 11'd0,   11'd400, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 11'd900, 11'd100, 1'b0, 1'b0, 11'd0,   11'd400, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 11'd900, 11'd100, 1'b0, 1'b0, 11'd767, 11'd400, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 11'd10,  11'd500, 1'b0, 1'b0, 11'd767, 11'd400, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 11'd10,  11'd500, 1'b0, 1'b0, 11'd767, 11'd400, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 11'd10,  11'd500, 1'b0, 1'b0, 11'd10,  11'd500, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 11'd300, 11'd450, 1'b1, 1'b1, 11'd10,  11'd500, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 11'd300, 11'd450, 1'b1, 1'b0, 11'd300, 11'd450, 1'b1, 1'b1};
        tbl[8]  = '{1'b0, 11'd300, 11'd450, 1'b1, 1'b0, 11'd300, 11'd450, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 11'd300, 11'd450, 1'b1, 1'b0, 11'd300, 11'd450, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 11'd300, 11'd450, 1'b1, 1'b1, 11'd300, 11'd450, 1'b0, 1'b0};
        rst_n = 1'b0;
        vblnk_in = 1'b1;
        xpos_in = 11'd900;
        ypos_in = 11'd100;
        left_in = 1'b0;
        shot_ack = 1'b0;
        repeat (3) @(posedge pclk);
        #1;
        chk_reset("reset");
        @(negedge pclk);
        rst_n = 1'b1;
        for (int i = 0; i < 11; i++) begin
            xpos_in = tbl[i].x;
            ypos_in = tbl[i].y;
            step(tbl[i].v, tbl[i].l, tbl[i].a);
            chk($sformatf("row%0d x", i), xpos_out, tbl[i].ex);
            chk($sformatf("row%0d y", i), ypos_out, tbl[i].ey);
            chk($sformatf("row%0d tick", i), {10'd0, frame_tick}, {10'd0, tbl[i].et});
            chk($sformatf("row%0d req", i), {10'd0, fire_req}, {10'd0, tbl[i].er});
        end
        cool_wait("cool1");
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b1, 1'b0);
            chk($sformatf("hold%0d req", k), {10'd0, fire_req}, 11'd1);
            step(1'b0, 1'b1, 1'b0);
            chk($sformatf("hold%0d gap req", k), {10'd0, fire_req}, 11'd1);
        end
        step(1'b0, 1'b1, 1'b1);
        chk("hold ack req", {10'd0, fire_req}, 11'd0);
        cool_wait("cool2");
        step(1'b1, 1'b1, 1'b1);
        chk("ack+cap tick", {10'd0, frame_tick}, 11'd1);
        chk("ack+cap req", {10'd0, fire_req}, 11'd0);
        step(1'b0, 1'b1, 1'b0);
        cool_wait("cool3");
        vblnk_in = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_reset("rst in REQ");
        @(negedge pclk);
        rst_n = 1'b1;
        xpos_in = 11'd5;
        ypos_in = 11'd600;
        step(1'b0, 1'b1, 1'b0);
        chk("post rst1 req", {10'd0, fire_req}, 11'd0);
        step(1'b1, 1'b1, 1'b0);
        chk("post rst1 x", xpos_out, 11'd5);
        chk("post rst1 y", ypos_out, 11'd567);
        chk("post rst1 req", {10'd0, fire_req}, 11'd1);
        step(1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b1, 1'b0);
            step(1'b0, 1'b1, 1'b0);
            chk($sformatf("cool4 f%0d req", k), {10'd0, fire_req}, 11'd0);
        end
        rst_n = 1'b0;
        #1;
        chk_reset("rst in COOL");
        @(negedge pclk);
        rst_n = 1'b1;
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("post rst2 tick", {10'd0, frame_tick}, 11'd1);
        chk("post rst2 req", {10'd0, fire_req}, 11'd1);
        step(1'b0, 1'b0, 1'b1);
        chk("post rst2 ack", {10'd0, fire_req}, 11'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
